// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and encodings for the pipeline hazard / forwarding controller.
// Scoreboard entries carry a fixed-width address so that any REG_AW up to SB_AW_MAX fits.
package pipeline_hazard_unit_pkg;

    localparam int SB_AW_MAX   = 8;
    localparam int SEL_REGFILE = 0;
    localparam logic [SB_AW_MAX-1:0] REG_ZERO = 8'd0;

    typedef struct packed {
        logic                 wr_en;
        logic [SB_AW_MAX-1:0] wr_addr;
        logic                 is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{wr_en: 1'b0, wr_addr: 8'd0, is_load: 1'b0};

    // r0 is hard-wired zero, so a write to it never produces a forwardable value.
    function automatic logic is_producer(input sb_entry_t e);
        return e.wr_en && (e.wr_addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage request / hazard-control response bundle.
// master = the ID stage driving instruction fields, slave = the hazard unit.
interface pipeline_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_wr_addr;
    logic              id_is_load;
    logic              id_redirect;
    logic              mem_ready;

    logic              stall_id;
    logic              freeze;
    logic              flush_ifid;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en,
               id_wr_addr, id_is_load, id_redirect, mem_ready,
        input  stall_id, freeze, flush_ifid, fwd_rs_sel, fwd_rt_sel, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en,
               id_wr_addr, id_is_load, id_redirect, mem_ready,
        output stall_id, freeze, flush_ifid, fwd_rs_sel, fwd_rt_sel, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_unit_hazard_match.sv
// Single-operand comparator against the in-flight write scoreboard: per-entry match
// vector, youngest-match forward select (k+1, 0 = register file) and EX-stage load-use flag.
module hazard_match
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  sb_entry_t [STAGES-1:0] sb,
    input  logic                   en,
    input  logic [REG_AW-1:0]      src,
    output logic [STAGES-1:0]      match,
    output logic [SEL_W-1:0]       sel,
    output logic                   load_use
);

    localparam logic [STAGES-1:0] LOAD_STAGE_MASK = {{(STAGES-1){1'b0}}, 1'b1};

    logic [SB_AW_MAX-1:0] src_ext_s;
    logic [STAGES-1:0]    load_vec_s;

    assign src_ext_s = SB_AW_MAX'(src);

    // Compare the source register against every scoreboard entry.
    always_comb begin
        match      = '0;
        load_vec_s = '0;
        for (int k = 0; k < STAGES; k++) begin
            match[k]      = en & is_producer(sb[k]) & (sb[k].wr_addr == src_ext_s);
            load_vec_s[k] = sb[k].is_load;
        end
    end

    // Scan oldest to youngest so the lowest matching index is the one that remains.
    always_comb begin
        sel = SEL_W'(SEL_REGFILE);
        for (int k = STAGES - 1; k >= 0; k--) begin
            sel = match[k] ? SEL_W'(k + 1) : sel;
        end
    end

    // A load still in EX has no result yet, so only entry 0 can raise load-use.
    assign load_use = |(match & load_vec_s & LOAD_STAGE_MASK);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller beside the ID stage: scoreboard, forward selects,
// load-use stall, memory-wait freeze, redirect flush and stall counter. Macro: FORWARD_EN.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_unit_if.slave hz
);

    sb_entry_t [STAGES-1:0] sb_r;
    logic [CNT_W-1:0]       cnt_r;

    logic [STAGES-1:0]      rs_match_s;
    logic [STAGES-1:0]      rt_match_s;
    logic [SEL_W-1:0]       rs_sel_s;
    logic [SEL_W-1:0]       rt_sel_s;
    logic                   rs_load_use_s;
    logic                   rt_load_use_s;
    logic                   stall_s;
    logic                   freeze_s;
    logic                   flush_s;
    sb_entry_t              id_entry_s;

    hazard_match #(
        .STAGES (STAGES),
        .REG_AW (REG_AW),
        .SEL_W  (SEL_W)
    ) u_match_rs (
        .sb       (sb_r),
        .en       (hz.id_valid & hz.id_use_rs),
        .src      (hz.id_rs),
        .match    (rs_match_s),
        .sel      (rs_sel_s),
        .load_use (rs_load_use_s)
    );

    hazard_match #(
        .STAGES (STAGES),
        .REG_AW (REG_AW),
        .SEL_W  (SEL_W)
    ) u_match_rt (
        .sb       (sb_r),
        .en       (hz.id_valid & hz.id_use_rt),
        .src      (hz.id_rt),
        .match    (rt_match_s),
        .sel      (rt_sel_s),
        .load_use (rt_load_use_s)
    );

`ifdef FORWARD_EN
    assign stall_s       = rs_load_use_s | rt_load_use_s;
    assign hz.fwd_rs_sel = rs_sel_s;
    assign hz.fwd_rt_sel = rt_sel_s;
`else
    // WB is excluded: the register file's write-first bypass already covers it.
    localparam logic [STAGES-1:0] INTERLOCK_MASK = {1'b0, {(STAGES-1){1'b1}}};
    logic unused_fwd_s;

    assign stall_s       = |((rs_match_s | rt_match_s) & INTERLOCK_MASK);
    assign hz.fwd_rs_sel = SEL_W'(SEL_REGFILE);
    assign hz.fwd_rt_sel = SEL_W'(SEL_REGFILE);
    assign unused_fwd_s  = ^{rs_sel_s, rt_sel_s, rs_load_use_s, rt_load_use_s};
`endif

    assign freeze_s = ~hz.mem_ready;
    // A stalled redirect waits; its operands are not final until the stall clears.
    assign flush_s  = hz.id_valid & hz.id_redirect & ~stall_s & ~freeze_s;

    assign hz.stall_id     = stall_s;
    assign hz.freeze       = freeze_s;
    assign hz.flush_ifid   = flush_s;
    assign hz.stall_cycles = cnt_r;

    // Entry pushed into EX: the ID instruction, or a bubble when ID is empty or stalled.
    always_comb begin
        id_entry_s = SB_BUBBLE;
        if (hz.id_valid && !stall_s) begin
            id_entry_s.wr_en   = hz.id_wr_en;
            id_entry_s.wr_addr = SB_AW_MAX'(hz.id_wr_addr);
            id_entry_s.is_load = hz.id_is_load;
        end else begin
            id_entry_s = SB_BUBBLE;
        end
    end

    // Scoreboard shift and stall-cycle counter; freeze holds the scoreboard only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_r  <= '0;
            cnt_r <= '0;
        end else begin
            if (stall_s || freeze_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (!freeze_s) begin
                sb_r <= {sb_r[STAGES-2:0], id_entry_s};
            end else begin
                sb_r <= sb_r;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed self-checking bench for pipeline_hazard_unit (STAGES = 3); expectations
// follow the FORWARD_EN build setting, which defaults to the full-interlock variant.
module tb_pipeline_hazard_unit;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_unit_if #(.REG_AW(5), .SEL_W(2), .CNT_W(32)) hif ();

    pipeline_hazard_unit #(
        .STAGES (3),
        .REG_AW (5),
        .CNT_W  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int we, input int rd, input int ld,
                         input int rs, input int urs, input int rt, input int urt,
                         input int redir);
        hif.id_valid    = 1'(v);
        hif.id_wr_en    = 1'(we);
        hif.id_wr_addr  = 5'(rd);
        hif.id_is_load  = 1'(ld);
        hif.id_rs       = 5'(rs);
        hif.id_use_rs   = 1'(urs);
        hif.id_rt       = 5'(rt);
        hif.id_use_rt   = 1'(urt);
        hif.id_redirect = 1'(redir);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        hif.mem_ready = 1'b1;
        idle();
        step();
        step();
        check("rst_stall",  32'(hif.stall_id),     0);
        check("rst_freeze", 32'(hif.freeze),       0);
        check("rst_flush",  32'(hif.flush_ifid),   0);
        check("rst_rs_sel", 32'(hif.fwd_rs_sel),   0);
        check("rst_rt_sel", 32'(hif.fwd_rt_sel),   0);
        check("rst_cnt",    32'(hif.stall_cycles), 0);
        hif.mem_ready = 1'b0;
        #1;
        check("rst_freeze_mem", 32'(hif.freeze), 1);
        hif.mem_ready = 1'b1;
        #1;
        rst = 1'b0;
        step();

        // Writes to r0 never create a dependency.
        drive(1, 1, 0, 0, 0, 1, 0, 0, 0);
        check("r0_wr_stall", 32'(hif.stall_id), 0);
        step();
        drive(1, 1, 7, 0, 0, 1, 0, 1, 0);
        check("r0_stall",  32'(hif.stall_id),   0);
        check("r0_rs_sel", 32'(hif.fwd_rs_sel), 0);
        check("r0_rt_sel", 32'(hif.fwd_rt_sel), 0);
        step();

        // Taken redirect with no operands flushes immediately.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("redir_flush", 32'(hif.flush_ifid), 1);
        check("redir_stall", 32'(hif.stall_id),   0);
        step();
        idle();
        step();

        // Producer r9 in EX, then three cycles of memory wait.
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0);
        step();
        hif.mem_ready = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            check("frz_freeze", 32'(hif.freeze),       1);
            check("frz_flush",  32'(hif.flush_ifid),   0);
            check("frz_cnt",    32'(hif.stall_cycles), 32'(i));
            step();
        end
        hif.mem_ready = 1'b1;
        drive(1, 0, 0, 0, 9, 1, 0, 0, 0);
        check("frz_release", 32'(hif.freeze),       0);
        check("frz_cnt3",    32'(hif.stall_cycles), 3);
        check("frz_held_stall",  32'(hif.stall_id),   FWD ? 0 : 1);
        check("frz_held_rs_sel", 32'(hif.fwd_rs_sel), FWD ? 1 : 0);
        step();
        idle();
        step();
        step();
        step();
        check("frz_cnt_after", 32'(hif.stall_cycles), FWD ? 3 : 4);

`ifdef FORWARD_EN
        // Back-to-back ALU dependencies, youngest producer wins.
        drive(1, 1, 1, 0, 2, 1, 3, 1, 0);
        check("f1_stall", 32'(hif.stall_id), 0);
        step();
        drive(1, 1, 1, 0, 1, 1, 5, 1, 0);
        check("f2_rs_sel", 32'(hif.fwd_rs_sel), 1);
        check("f2_rt_sel", 32'(hif.fwd_rt_sel), 0);
        check("f2_stall",  32'(hif.stall_id),   0);
        step();
        drive(1, 1, 4, 0, 1, 1, 1, 1, 0);
        check("f3_rs_sel", 32'(hif.fwd_rs_sel), 1);
        check("f3_rt_sel", 32'(hif.fwd_rt_sel), 1);
        step();
        drive(1, 0, 0, 0, 1, 1, 4, 1, 0);
        check("f4_rs_sel", 32'(hif.fwd_rs_sel), 2);
        check("f4_rt_sel", 32'(hif.fwd_rt_sel), 1);
        step();
        check("f5_rs_sel", 32'(hif.fwd_rs_sel), 3);
        check("f5_rt_sel", 32'(hif.fwd_rt_sel), 2);
        step();
        idle();
        step();
        step();
        step();

        // Load-use: one stall cycle, then forward from MEM.
        drive(1, 1, 3, 1, 0, 1, 0, 0, 0);
        check("lu_lw_stall", 32'(hif.stall_id), 0);
        step();
        drive(1, 1, 6, 0, 3, 1, 3, 1, 0);
        check("lu_stall",  32'(hif.stall_id),     1);
        check("lu_rs_sel", 32'(hif.fwd_rs_sel),   1);
        check("lu_rt_sel", 32'(hif.fwd_rt_sel),   1);
        check("lu_cnt",    32'(hif.stall_cycles), 3);
        step();
        check("lu2_stall",  32'(hif.stall_id),     0);
        check("lu2_rs_sel", 32'(hif.fwd_rs_sel),   2);
        check("lu2_rt_sel", 32'(hif.fwd_rt_sel),   2);
        check("lu2_cnt",    32'(hif.stall_cycles), 4);
        step();

        // Load-use branch under freeze: no advance, flush deferred past the stall.
        drive(1, 1, 8, 1, 0, 0, 0, 0, 0);
        step();
        hif.mem_ready = 1'b0;
        drive(1, 0, 0, 0, 8, 1, 0, 0, 1);
        check("fl_stall",  32'(hif.stall_id),     1);
        check("fl_freeze", 32'(hif.freeze),       1);
        check("fl_flush",  32'(hif.flush_ifid),   0);
        check("fl_cnt",    32'(hif.stall_cycles), 4);
        step();
        hif.mem_ready = 1'b1;
        #1;
        check("fl2_stall", 32'(hif.stall_id),     1);
        check("fl2_flush", 32'(hif.flush_ifid),   0);
        check("fl2_cnt",   32'(hif.stall_cycles), 5);
        step();
        check("fl3_stall",  32'(hif.stall_id),     0);
        check("fl3_flush",  32'(hif.flush_ifid),   1);
        check("fl3_rs_sel", 32'(hif.fwd_rs_sel),   2);
        check("fl3_cnt",    32'(hif.stall_cycles), 6);
        step();

        // Reset during a load-use stall discards the pending load.
        drive(1, 1, 5, 1, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
        check("rr_stall", 32'(hif.stall_id), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rr_stall_after", 32'(hif.stall_id),     0);
        check("rr_rs_sel",      32'(hif.fwd_rs_sel),   0);
        check("rr_cnt",         32'(hif.stall_cycles), 0);
`else
        // Full interlock: dependency in EX or MEM stalls, WB does not.
        drive(1, 1, 1, 0, 2, 1, 3, 1, 0);
        check("i1_stall", 32'(hif.stall_id), 0);
        step();
        drive(1, 1, 2, 0, 1, 1, 5, 1, 0);
        check("i2_stall",  32'(hif.stall_id),     1);
        check("i2_rs_sel", 32'(hif.fwd_rs_sel),   0);
        check("i2_cnt",    32'(hif.stall_cycles), 4);
        step();
        check("i3_stall", 32'(hif.stall_id),     1);
        check("i3_cnt",   32'(hif.stall_cycles), 5);
        step();
        check("i4_stall",  32'(hif.stall_id),     0);
        check("i4_rs_sel", 32'(hif.fwd_rs_sel),   0);
        check("i4_cnt",    32'(hif.stall_cycles), 6);
        step();

        // Branch on a just-loaded register: flush only once the interlock clears.
        drive(1, 1, 3, 1, 0, 1, 0, 0, 0);
        check("ib_lw_stall", 32'(hif.stall_id), 0);
        step();
        drive(1, 0, 0, 0, 3, 1, 0, 1, 1);
        check("ib1_stall", 32'(hif.stall_id),   1);
        check("ib1_flush", 32'(hif.flush_ifid), 0);
        step();
        check("ib2_stall", 32'(hif.stall_id),     1);
        check("ib2_flush", 32'(hif.flush_ifid),   0);
        check("ib2_cnt",   32'(hif.stall_cycles), 7);
        step();
        check("ib3_stall", 32'(hif.stall_id),     0);
        check("ib3_flush", 32'(hif.flush_ifid),   1);
        check("ib3_cnt",   32'(hif.stall_cycles), 8);
        step();

        // Reset during an interlock stall clears it in the next cycle.
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
        check("rr_stall", 32'(hif.stall_id), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rr_stall_after", 32'(hif.stall_id),     0);
        check("rr_cnt",         32'(hif.stall_cycles), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised hazard and forwarding controller for the pipelined CPU. It sits beside the ID stage and keeps a per-stage scoreboard of in-flight register writes (EX, MEM, WB, and any further stages). From that scoreboard it produces operand-forwarding selects, load-use stalls, memory-wait freezes and the IF/ID flush for taken branches and jumps. It replaces the old "stall on any pending write" interlock with real forwarding, while keeping the full interlock available as a build option.

## Interface
- STAGES, 3, number of tracked stages after ID; entry 0 = EX, entry STAGES-1 = WB
- REG_AW, 5, register address width
- CNT_W, 32, width of the stall-cycle counter
- SEL_W, $clog2(STAGES+1), width of forward selects (derived)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source register numbers
- id_use_rs, id_use_rt  in  1  instruction reads rs / rt
- id_wr_en  in  1  instruction writes the register file
- id_wr_addr  in  REG_AW  destination register
- id_is_load  in  1  instruction is a load (result available after MEM)
- id_redirect  in  1  branch taken or j/jal/jr resolved in ID
- mem_ready  in  1  data memory ready (MIO_ready); 0 = wait
- stall_id  out  1  hold PC and IF/ID, inject bubble into EX
- freeze  out  1  hold every pipeline register
- flush_ifid  out  1  squash the instruction in IF/ID
- fwd_rs_sel, fwd_rt_sel  out  SEL_W  0 = register file, k+1 = result of entry k
- stall_cycles  out  CNT_W  count of cycles with stall_id or freeze

## Operation
- Scoreboard: STAGES entries of {wr_en, wr_addr, is_load}.
- An entry with wr_en = 1 and wr_addr ≠ 0 is a producer. Register 0 never matches.
- Match for rs: id_valid & id_use_rs & producer(k) & wr_addr(k) == id_rs. The same rule applies to rt.
- Forwarding select:
  - Youngest matching entry wins (lowest k).
  - fwd_*_sel = k+1.
  - With no match, fwd_*_sel = 0.
- Load-use: a match at entry 0 with is_load = 1 raises stall_id. Selects still reflect the match; the datapath ignores them while stalled.
- freeze = ~mem_ready. freeze dominates:
  - the scoreboard holds;
  - flush_ifid = 0;
  - the counter still increments.
- flush_ifid = id_valid & id_redirect & ~stall_id & ~freeze. A redirect whose operands are stalled waits until the stall clears.
- Scoreboard advance (when ~freeze, at the clk edge):
  - entry k+1 ← entry k;
  - entry 0 ← ID fields if id_valid & ~stall_id, otherwise a bubble (wr_en = 0).
- Counter: increments on every cycle with stall_id | freeze and wraps modulo 2^CNT_W.

## Timing
- All outputs except stall_cycles are combinational from scoreboard registers and ID inputs. They are valid in the same cycle as the ID inputs.
- Scoreboard and counter update on the rising clk edge.
- Reset: all entries cleared to wr_en = 0 and stall_cycles = 0. With idle inputs, outputs after reset are stall_id = 0, freeze = ~mem_ready, flush_ifid = 0, selects = 0.
- Reset mid-operation discards every pending write; there is no stall in the following cycle.
- Load-use costs exactly 1 stall cycle. The next cycle the load sits in entry 1 and the select becomes 2.
- Simultaneous stall and redirect: the stall wins, and the flush is deferred one cycle.
- Simultaneous freeze and load-use: no advance. The load-use stall persists until freeze drops.

## Configuration
- FORWARD_EN defined: forwarding as described.
- FORWARD_EN undefined (full interlock):
  - fwd_*_sel are tied to 0;
  - stall_id is raised for any match in entries 0..STAGES-2;
  - entry STAGES-1 (WB) is covered by the register file's write-first bypass and never stalls.

## Structure
- Shared package: the scoreboard entry struct, and localparams for select encoding (SEL_REGFILE = 0) and REG_ZERO.
- One sub-module, hazard_match: a single-operand comparator producing match vector, youngest index and load-use flag. It is instantiated twice, for rs and rt.

## Test plan
1. add r1,r2,r3 then add r4,r1,r5 back-to-back, FORWARD_EN on -> fwd_rs_sel = 1, stall_id = 0.
2. lw r3,0(r0) then add r6,r3,r3 -> stall_id = 1 for one cycle, then fwd_rs_sel = fwd_rt_sel = 2; stall_cycles +1.
3. addi r0,r0,5 then add r7,r0,r0 -> no match, selects 0, no stall.
4. mem_ready low for 3 cycles with a producer in entry 0 -> freeze = 1 for 3 cycles, scoreboard unchanged, stall_cycles +3, flush_ifid = 0.
5. beq taken, no hazard -> flush_ifid = 1 for one cycle. beq dependent on a preceding lw -> flush_ifid = 0 in the stall cycle, 1 in the next.
6. FORWARD_EN off, STAGES = 3: add r1 then add r2,r1 -> stall_id high for 2 cycles, then low with select 0; reset asserted during the stall clears it in the next cycle.
